// File: rtl/crc16_pkg.sv
// Shared constants and state encoding for the serial CRC-16 transmitter and checker.
package crc16_pkg;

  localparam int          DATA_W     = 23;
  localparam int          CRC_W      = 16;
  localparam int          MSG_W      = DATA_W + CRC_W;
  localparam logic [15:0] CRC16_POLY = 16'h8005;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } crc_tx_state_t;

endpackage

// File: rtl/crc16_step.sv
// One serial CRC-16 division step: shifts a single message bit into the remainder.
// The x^16 term of the generator is implicit in the feedback bit.
module crc16_step
  import crc16_pkg::*;
(
  input  logic [CRC_W-1:0] rem,
  input  logic             din,
  input  logic [CRC_W-1:0] poly,
  output logic [CRC_W-1:0] rem_next
);

  logic fb_s;

  // Feedback is the bit that falls off the top of the remainder, mixed with the incoming bit.
  always_comb begin
    fb_s = rem[CRC_W-1] ^ din;
    if (fb_s) begin
      rem_next = {rem[CRC_W-2:0], 1'b0} ^ poly;
    end else begin
      rem_next = {rem[CRC_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/crc16_transmitter.sv
// Serial CRC-16 encoder: accepts a payload, divides it MSB first one bit per clock,
// then presents {payload, crc} until the sink takes it.
module crc16_transmitter
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY   = CRC16_POLY,
  parameter int          DATA_W = crc16_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W+15:0]    out_message,
  output logic                  busy
);

  localparam int              CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  crc_tx_state_t           state_r, state_s;
  logic [DATA_W-1:0]       data_r, data_s;
  logic [DATA_W-1:0]       shift_r, shift_s;
  logic [15:0]             rem_r, rem_s, step_rem_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [DATA_W+15:0]      msg_r, msg_s;
  logic                    in_ready_r, in_ready_s;
  logic                    out_valid_r, out_valid_s;
  logic                    busy_r, busy_s;

  crc16_step u_step (
    .rem      (rem_r),
    .din      (shift_r[DATA_W-1]),
    .poly     (POLY),
    .rem_next (step_rem_s)
  );

  // Next-state, datapath and output decode; outputs are computed from the next state so they register cleanly.
  always_comb begin
    state_s = state_r;
    data_s  = data_r;
    shift_s = shift_r;
    rem_s   = rem_r;
    cnt_s   = cnt_r;
    msg_s   = msg_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = SHIFT;
          data_s  = in_data;
          shift_s = in_data;
          rem_s   = 16'h0000;
          cnt_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        rem_s   = step_rem_s;
        shift_s = {shift_r[DATA_W-2:0], 1'b0};
        cnt_s   = cnt_r + CNT_W'(1);
        if (cnt_r == LAST_STEP) begin
          state_s = DONE;
          msg_s   = {data_r, step_rem_s};
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
          msg_s   = '0;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        msg_s   = '0;
      end
    endcase
    in_ready_s  = (state_s == IDLE);
    out_valid_s = (state_s == DONE);
    busy_s      = (state_s == SHIFT) || (state_s == DONE);
  end

  // State, datapath and output registers; reset discards any message in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      data_r      <= '0;
      shift_r     <= '0;
      rem_r       <= 16'h0000;
      cnt_r       <= '0;
      msg_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      data_r      <= data_s;
      shift_r     <= shift_s;
      rem_r       <= rem_s;
      cnt_r       <= cnt_s;
      msg_r       <= msg_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_message = msg_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_crc16_transmitter.sv
// Self-checking bench for crc16_transmitter: directed vectors, backpressure, reset abort
// and randomized payloads against a long-division reference model.
module tb_crc16_transmitter;

  localparam logic [16:0] GEN = 17'h18005;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [38:0] out_message;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  crc16_transmitter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_message (out_message),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Free-running edge counter for latency and throughput measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [38:0] obs, input logic [38:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Remainder of a 39-bit value divided by x^16+x^15+x^2+1 using schoolbook long division.
  function automatic logic [15:0] poly_mod(input logic [38:0] v);
    logic [38:0] r;
    r = v;
    for (int i = 38; i >= 16; i--) begin
      if (r[i]) r = r ^ (39'(GEN) << (i - 16));
    end
    return r[15:0];
  endfunction

  function automatic logic [38:0] ref_codeword(input logic [22:0] p);
    return {p, poly_mod({p, 16'h0000})};
  endfunction

  // Offer a payload from IDLE, scramble inputs while busy, and wait for the codeword.
  task automatic send_msg(input logic [22:0] p, output logic [38:0] msg, output int acc);
    int lat;
    check_eq("in_ready_idle", 39'(in_ready), 39'd1);
    in_valid = 1'b1;
    in_data  = p;
    @(negedge clk);
    acc      = cyc;
    in_valid = 1'b0;
    in_data  = 23'($urandom);
    check_eq("busy_after_accept", 39'(busy), 39'd1);
    check_eq("in_ready_after_accept", 39'(in_ready), 39'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 23'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    msg = out_message;
    check_eq("latency", 39'(lat), 39'd23);
  endtask

  // Full transfer with out_ready already high; ends in IDLE one cycle after the handshake.
  task automatic do_msg(input logic [22:0] p, input logic [38:0] exp, output int acc);
    logic [38:0] msg;
    send_msg(p, msg, acc);
    check_eq("codeword", msg, exp);
    check_eq("checker_rem", 39'(poly_mod(msg)), 39'h0);
    @(negedge clk);
    check_eq("out_valid_after_hs", 39'(out_valid), 39'd0);
    check_eq("in_ready_after_hs", 39'(in_ready), 39'd1);
  endtask

  initial begin
    logic [38:0] msg;
    logic [38:0] exp;
    logic [22:0] p;
    int          acc;
    int          prev_acc;
    int          spurious;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 23'h0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 39'(out_valid), 39'd0);
    check_eq("rst_busy", 39'(busy), 39'd0);
    check_eq("rst_out_message", out_message, 39'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 39'(in_ready), 39'd1);

    // Directed vectors, including linearity of the CRC.
    do_msg(23'h000000, 39'h00_0000_0000, acc);
    do_msg(23'h000001, 39'h00_0001_8005, acc);
    do_msg(23'h000002, 39'h00_0002_800F, acc);
    do_msg(23'h000003, 39'h00_0003_000A, acc);

    // Backpressure: codeword held, inputs ignored, IDLE one cycle after out_ready.
    out_ready = 1'b0;
    p   = 23'($urandom);
    exp = ref_codeword(p);
    send_msg(p, msg, acc);
    check_eq("bp_codeword", msg, exp);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 23'($urandom);
      @(negedge clk);
      check_eq("bp_hold", out_message, exp);
      check_eq("bp_valid", 39'(out_valid), 39'd1);
      check_eq("bp_in_ready", 39'(in_ready), 39'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_valid", 39'(out_valid), 39'd0);
    check_eq("bp_release_ready", 39'(in_ready), 39'd1);

    // Reset in the middle of SHIFT aborts the message.
    in_valid = 1'b1;
    in_data  = 23'($urandom);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", 39'(out_valid), 39'd0);
    check_eq("abort_busy", 39'(busy), 39'd0);
    check_eq("abort_out_message", out_message, 39'h0);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    check_eq("abort_no_codeword", 39'(spurious), 39'd0);
    do_msg(23'h000001, 39'h00_0001_8005, acc);

    // Randomized payloads back to back with out_ready high.
    prev_acc = -1;
    for (int i = 0; i < 1000; i++) begin
      p = 23'($urandom);
      do_msg(p, ref_codeword(p), acc);
      if (prev_acc >= 0) check_eq("throughput", 39'(acc - prev_acc), 39'd25);
      prev_acc = acc;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
